ram_upload_reader: RTL and testbench
====================================

Name: ram_upload_reader

Overview:
- Responder for the HPS ioctl upload path: on host read strobes it fetches bytes from the cartridge RAM's read port and returns them with a wait/valid handshake.
- Sits beside the cartridge download writer, sharing the cart RAM, and is used for cart-RAM dumps and verification read-back.
- Serves one byte per request and returns 8'hFF for addresses outside the loaded image.

Parameters:
- AW, 16, RAM address width; ram_addr = ioctl_addr[AW-1:0].
- RAM_LAT, 1, RAM read latency in clk_sys cycles from ram_addr to ram_data valid; legal 1..3.
- SIZE_W, 20, width of upload_size and bytes_read.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  high for the duration of an upload session.
- ioctl_rd  in  1  one-cycle read request strobe from host.
- ioctl_addr  in  25  byte address of the request, valid with ioctl_rd.
- upload_size  in  SIZE_W  number of valid image bytes; sampled at session start.
- ioctl_din  out  8  returned byte; valid when ioctl_wait is low after a request.
- ioctl_wait  out  1  high while a request is in service.
- ram_addr  out  AW  RAM read address.
- ram_data  in  8  RAM read data.
- busy  out  1  high while the session is active (state != IDLE).
- done  out  1  one-cycle pulse at session end.
- overrun  out  1  sticky: an ioctl_rd arrived while ioctl_wait was high.
- bytes_read  out  SIZE_W  completed requests this session; saturates at all-ones.

Behaviour:
- Reset values: ioctl_din=8'h00, ioctl_wait=0, ram_addr=0, busy=0, done=0, overrun=0, bytes_read=0; state IDLE.
- IDLE -> ARMED on the first cycle ioctl_upload=1.
  - Latch upload_size into size_q.
  - Clear overrun and bytes_read.
  - ioctl_rd in that same cycle is ignored.
- ARMED with ioctl_rd=1, address in range (ioctl_addr < size_q and ioctl_addr[24:AW]==0):
  - Next cycle: ram_addr=ioctl_addr[AW-1:0], ioctl_wait=1, latency counter=RAM_LAT, state FETCH.
- ARMED with ioctl_rd=1, address out of range:
  - Next cycle: ioctl_din=8'hFF, ioctl_wait stays 0, bytes_read+1.
  - No RAM access; ram_addr holds its previous value.
- FETCH: counter decrements each cycle. In the cycle the counter reaches 0:
  - Capture ram_data into ioctl_din.
  - ioctl_wait=0, bytes_read+1, state ARMED.
- Latency, in-range request: ioctl_rd at cycle N -> ioctl_wait high in N+1..N+RAM_LAT; ioctl_din valid and ioctl_wait low at N+RAM_LAT+1.
- Latency, out-of-range request: ioctl_din valid at N+1.
- ioctl_rd while FETCH: the request is dropped and overrun is set (sticky until the next session start). The in-flight fetch completes normally.
- ARMED ioctl_rd in the same cycle the FETCH completes cannot occur, because state is FETCH in that cycle; the request counts as an overrun.
- ioctl_upload falling in any non-IDLE state:
  - Next cycle: state IDLE, ioctl_wait=0, done=1 for one cycle.
  - An in-flight fetch is abandoned; ioctl_din keeps its last value.
  - bytes_read and overrun hold until the next session start.
- upload_size=0: every request returns 8'hFF.
- upload_size changes mid-session: ignored (size_q is used).
- bytes_read stays at all-ones once reached; there is no wrap.
- Asynchronous reset mid-fetch forces all reset values immediately, with no done pulse.
- busy = (state != IDLE), registered.

Test Plan:
- Reset asserted mid-FETCH with ioctl_wait=1 -> all outputs return to reset values asynchronously; no done pulse.
- RAM_LAT=1, RAM[0x0010]=8'h5A, upload_size=0x1000, ioctl_rd at addr 0x10 -> ioctl_wait high exactly 1 cycle, ioctl_din=8'h5A at N+2, bytes_read=1.
- RAM_LAT=3, 4 sequential reads at addr 0..3 (RAM=11,22,33,44), each issued after wait drops -> ioctl_din sequence 11,22,33,44; wait high 3 cycles each; bytes_read=4; overrun=0.
- upload_size=0x0800, read at addr 0x0800 and at 0x10000 -> ioctl_din=8'hFF at N+1, ioctl_wait never high, ram_addr unchanged.
- Second ioctl_rd issued one cycle after the first with RAM_LAT=2 -> second request dropped, overrun=1, first byte still returned; overrun clears at the next upload start.
- ioctl_upload dropped during FETCH -> next cycle ioctl_wait=0, busy=0, done pulses 1 cycle; a new session re-latches upload_size and zeroes bytes_read.

Source files
------------

// File: rtl/ram_upload_reader.sv
// Upload-path read responder: serves host ioctl byte reads from the cart RAM read port,
// answering 8'hFF for addresses outside the image latched at session start.
module ram_upload_reader #(
    parameter int unsigned AW      = 16,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned SIZE_W  = 20
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [SIZE_W-1:0] upload_size,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [AW-1:0]     ram_addr,
    input  logic [7:0]        ram_data,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [SIZE_W-1:0] bytes_read
);

    typedef enum logic [1:0] {StIdle, StArmed, StFetch} state_e;

    state_e            state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] bytes_q, bytes_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;

    logic              in_range;
    logic [SIZE_W-1:0] bytes_inc;

    // Bits above the RAM address width must be clear as well as being below the image size.
    assign in_range  = ((ioctl_addr >> AW) == 25'd0) && (32'(ioctl_addr) < 32'(size_q));
    assign bytes_inc = (&bytes_q) ? bytes_q : bytes_q + 1'b1;

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        bytes_d = bytes_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ioctl_upload) begin
                    state_d = StArmed;
                    size_d  = upload_size;
                    bytes_d = '0;
                    ovr_d   = 1'b0;
                end
            end
            StArmed: begin
                if (!ioctl_upload) begin
                    state_d = StIdle;
                    wait_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (ioctl_rd) begin
                    if (in_range) begin
                        state_d = StFetch;
                        addr_d  = ioctl_addr[AW-1:0];
                        wait_d  = 1'b1;
                        cnt_d   = 2'(RAM_LAT);
                    end else begin
                        din_d   = 8'hFF;
                        bytes_d = bytes_inc;
                    end
                end
            end
            StFetch: begin
                if (!ioctl_upload) begin
                    state_d = StIdle;
                    wait_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    if (ioctl_rd) begin
                        ovr_d = 1'b1;
                    end
                    // Last wait cycle: RAM data is valid now, so capture on this edge.
                    if (cnt_q == 2'd1) begin
                        state_d = StArmed;
                        din_d   = ram_data;
                        wait_d  = 1'b0;
                        bytes_d = bytes_inc;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            size_q  <= '0;
            bytes_q <= '0;
            cnt_q   <= '0;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            bytes_q <= bytes_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = ovr_q;
    assign bytes_read = bytes_q;

endmodule

// File: tb/tb_ram_upload_reader.sv
// Bench for ram_upload_reader: three instances (RAM_LAT 1..3) share stimulus, each checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_ram_upload_reader;

    localparam int Period = 10;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        upload;
    logic        rd;
    logic [24:0] addr;
    logic [19:0] usize;

    logic [7:0]  din    [3];
    logic        wt     [3];
    logic [15:0] raddr  [3];
    logic        bsy    [3];
    logic        dn     [3];
    logic        ovr    [3];
    logic [19:0] nbytes [3];

    logic [7:0]  mem [65536];

    int total = 0;
    int bad   = 0;

    always #(Period / 2) clk_sys = ~clk_sys;

    task automatic chk(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lat%0d: got %h want %h at %0t", name, g + 1, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int unsigned Lat = g + 1;

        logic [7:0] rd_data;
        logic [7:0] pipe [2];

        // RAM read port: data for ram_addr appears Lat cycles after the address is presented.
        always @(posedge clk_sys) begin
            pipe[0] <= mem[raddr[g]];
            pipe[1] <= pipe[0];
        end
        if (g == 0) begin : g_comb
            assign rd_data = mem[raddr[g]];
        end else begin : g_pipe
            assign rd_data = pipe[g-1];
        end

        ram_upload_reader #(
            .AW      (16),
            .RAM_LAT (Lat),
            .SIZE_W  (20)
        ) dut (
            .clk_sys      (clk_sys),
            .reset        (reset),
            .ioctl_upload (upload),
            .ioctl_rd     (rd),
            .ioctl_addr   (addr),
            .upload_size  (usize),
            .ioctl_din    (din[g]),
            .ioctl_wait   (wt[g]),
            .ram_addr     (raddr[g]),
            .ram_data     (rd_data),
            .busy         (bsy[g]),
            .done         (dn[g]),
            .overrun      (ovr[g]),
            .bytes_read   (nbytes[g])
        );

        bit          m_sess, m_pend, m_done, m_ovr;
        logic [19:0] m_size, m_bytes;
        logic [7:0]  m_din;
        logic [15:0] m_raddr;
        time         m_ready;

        // Session/transaction view: a pending fetch finishes Lat clocks after its request.
        initial forever begin : model
            bit was_pend;
            @(posedge clk_sys);
            if (reset) begin
                m_sess = 0; m_pend = 0; m_done = 0; m_ovr = 0;
                m_size = '0; m_bytes = '0; m_din = 8'h00; m_raddr = '0; m_ready = 0;
            end else begin
                m_done = 0;
                if (!m_sess) begin
                    if (upload) begin
                        m_sess = 1; m_size = usize; m_bytes = '0; m_ovr = 0;
                    end
                end else if (!upload) begin
                    m_sess = 0; m_pend = 0; m_done = 1;
                end else begin
                    was_pend = m_pend;
                    if (m_pend && $time == m_ready) begin
                        m_din = mem[m_raddr];
                        m_bytes = (m_bytes == 20'hFFFFF) ? m_bytes : m_bytes + 20'd1;
                        m_pend = 0;
                    end
                    if (rd) begin
                        if (was_pend) begin
                            m_ovr = 1;
                        end else if (32'(addr) < 32'(m_size) && addr < 25'h10000) begin
                            m_pend = 1; m_raddr = addr[15:0];
                            m_ready = $time + Lat * Period;
                        end else begin
                            m_din = 8'hFF;
                            m_bytes = (m_bytes == 20'hFFFFF) ? m_bytes : m_bytes + 20'd1;
                        end
                    end
                end
            end
        end

        initial forever begin : compare
            @(posedge clk_sys);
            #3;
            chk("din",   g, 32'(din[g]),    reset ? 32'd0 : 32'(m_din));
            chk("wait",  g, 32'(wt[g]),     reset ? 32'd0 : 32'(m_pend));
            chk("raddr", g, 32'(raddr[g]),  reset ? 32'd0 : 32'(m_raddr));
            chk("busy",  g, 32'(bsy[g]),    reset ? 32'd0 : 32'(m_sess));
            chk("done",  g, 32'(dn[g]),     reset ? 32'd0 : 32'(m_done));
            chk("ovr",   g, 32'(ovr[g]),    reset ? 32'd0 : 32'(m_ovr));
            chk("bytes", g, 32'(nbytes[g]), reset ? 32'd0 : 32'(m_bytes));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic start_session(input logic [19:0] sz);
        upload = 1'b0;
        cyc(2);
        usize  = sz;
        upload = 1'b1;
        cyc(2);
    endtask

    // Returns in the cycle after the request (N+1).
    task automatic read(input logic [24:0] a);
        rd   = 1'b1;
        addr = a;
        cyc(1);
        rd   = 1'b0;
    endtask

    function automatic logic [19:0] pick_size();
        case ($urandom_range(0, 3))
            0:       return 20'h0;
            1:       return 20'($urandom_range(1, 'h30));
            2:       return 20'h12000;
            default: return 20'($urandom_range('h10, 'h40));
        endcase
    endfunction

    initial begin
        logic [7:0] seq [4];
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b1; upload = 1'b0; rd = 1'b0; addr = '0; usize = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h5A; mem[5] = 8'hC3;
        for (int i = 0; i < 4; i++) mem[i] = seq[i];
        cyc(3);
        for (int g = 0; g < 3; g++) begin
            chk("rst_din", g, 32'(din[g]), 32'h0);
            chk("rst_wait", g, 32'(wt[g]), 32'h0);
            chk("rst_busy", g, 32'(bsy[g]), 32'h0);
        end
        reset = 1'b0;
        cyc(1);

        // RAM_LAT=1 single read
        start_session(20'h01000);
        read(25'h10);
        chk("t1_wait_n1", 0, 32'(wt[0]), 32'd1);
        cyc(1);
        chk("t1_wait_n2", 0, 32'(wt[0]), 32'd0);
        chk("t1_din", 0, 32'(din[0]), 32'h5A);
        chk("t1_bytes", 0, 32'(nbytes[0]), 32'd1);
        cyc(3);

        // RAM_LAT=3 sequential reads, each after wait drops
        start_session(20'h01000);
        for (int i = 0; i < 4; i++) begin
            int n;
            read(25'(i));
            n = 0;
            while (wt[2] && n < 10) begin
                n++;
                cyc(1);
            end
            chk("t2_wait_len", 2, 32'(n), 32'd3);
            chk("t2_din", 2, 32'(din[2]), 32'(seq[i]));
        end
        chk("t2_bytes", 2, 32'(nbytes[2]), 32'd4);
        chk("t2_ovr", 2, 32'(ovr[2]), 32'd0);

        // Out-of-range reads: size boundary and high address bits
        start_session(20'h00800);
        read(25'h800);
        for (int g = 0; g < 3; g++) begin
            chk("t3_din_a", g, 32'(din[g]), 32'hFF);
            chk("t3_wait_a", g, 32'(wt[g]), 32'd0);
            chk("t3_raddr_a", g, 32'(raddr[g]), 32'h3);
        end
        cyc(1);
        read(25'h10000);
        chk("t3_din_b", 2, 32'(din[2]), 32'hFF);
        chk("t3_wait_b", 2, 32'(wt[2]), 32'd0);
        chk("t3_raddr_b", 2, 32'(raddr[2]), 32'h3);
        chk("t3_bytes", 2, 32'(nbytes[2]), 32'd2);

        // Back-to-back request on RAM_LAT=2 is dropped as an overrun
        start_session(20'h01000);
        rd = 1'b1; addr = 25'h5;
        cyc(1);
        addr = 25'h6;
        cyc(1);
        rd = 1'b0;
        chk("t4_ovr", 1, 32'(ovr[1]), 32'd1);
        chk("t4_wait", 1, 32'(wt[1]), 32'd1);
        cyc(1);
        chk("t4_wait_end", 1, 32'(wt[1]), 32'd0);
        chk("t4_din", 1, 32'(din[1]), 32'hC3);
        chk("t4_bytes", 1, 32'(nbytes[1]), 32'd1);
        start_session(20'h01000);
        chk("t4_ovr_clr", 1, 32'(ovr[1]), 32'd0);

        // Upload dropped during a fetch
        read(25'h7);
        chk("t5_wait", 2, 32'(wt[2]), 32'd1);
        upload = 1'b0;
        cyc(1);
        chk("t5_wait_drop", 2, 32'(wt[2]), 32'd0);
        chk("t5_busy", 2, 32'(bsy[2]), 32'd0);
        chk("t5_done", 2, 32'(dn[2]), 32'd1);
        cyc(1);
        chk("t5_done_end", 2, 32'(dn[2]), 32'd0);
        usize = 20'h00020; upload = 1'b1;
        cyc(2);
        chk("t5_bytes_clr", 2, 32'(nbytes[2]), 32'd0);
        usize = 20'h0FFFF;
        read(25'h21);
        chk("t5_size_latched", 0, 32'(din[0]), 32'hFF);
        chk("t5_size_wait", 0, 32'(wt[0]), 32'd0);
        cyc(4);

        // Asynchronous reset mid-fetch
        read(25'h1);
        chk("t6_wait", 2, 32'(wt[2]), 32'd1);
        reset = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("t6_din", g, 32'(din[g]), 32'h0);
            chk("t6_wait_rst", g, 32'(wt[g]), 32'h0);
            chk("t6_busy", g, 32'(bsy[g]), 32'h0);
            chk("t6_bytes", g, 32'(nbytes[g]), 32'h0);
            chk("t6_raddr", g, 32'(raddr[g]), 32'h0);
        end
        cyc(2);
        reset = 1'b0;
        upload = 1'b0;
        cyc(2);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rd = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0, 1:    addr = 25'($urandom_range(0, 'h40));
                2:       addr = 25'($urandom_range('h10000, 'h10020));
                default: addr = 25'($urandom);
            endcase
            if ($urandom_range(0, 59) == 0) upload = ~upload;
            if ($urandom_range(0, 39) == 0) usize = pick_size();
            reset = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        reset = 1'b0; rd = 1'b0; upload = 1'b0;
        cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
